// File: rtl/ddr2_app_pkg.sv
// ddr2_app_pkg: shared commands, FSM states and address helper for the DDR2 app arbiter
package ddr2_app_pkg;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {WAIT_INIT, IDLE, WR_B0, WR_B1, RD_CMD} state_e;

    // BL4 bursts start on a 4-column boundary
    function automatic logic [63:0] burst_addr_mask(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction
endpackage

// File: rtl/ddr2_rd_tracker.sv
// ddr2_rd_tracker: read return register, outstanding-burst counter and underflow flag
module ddr2_rd_tracker #(
    parameter int APPDATA_WIDTH = 32,
    parameter int BURST_BEATS   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_i,
    input  logic                     rd_data_valid_i,
    input  logic [APPDATA_WIDTH-1:0] rd_data_fifo_out_i,
    output logic                     rd_valid_o,
    output logic [APPDATA_WIDTH-1:0] rd_data_o,
    output logic [3:0]               outstanding_o
);
    localparam int BW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;

    logic [BW-1:0]            beat_q;
    logic [3:0]               cnt_q;
    logic                     valid_q;
    logic                     err_underflow_q;
    logic [APPDATA_WIDTH-1:0] data_q;
    logic                     have, last_beat, dec;

    assign have      = cnt_q != 4'd0;
    assign last_beat = beat_q == BW'(BURST_BEATS - 1);
    assign dec       = rd_data_valid_i & have & last_beat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q          <= '0;
            cnt_q           <= '0;
            valid_q         <= 1'b0;
            data_q          <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            valid_q <= rd_data_valid_i;
            data_q  <= rd_data_fifo_out_i;
            // stray beats with nothing outstanding are forwarded but not counted
            if (rd_data_valid_i & have) beat_q <= last_beat ? '0 : beat_q + BW'(1);
            cnt_q <= cnt_q + {3'd0, issue_i} - {3'd0, dec};
            if (rd_data_valid_i & ~have) err_underflow_q <= 1'b1;
        end
    end

    assign rd_valid_o    = valid_q;
    assign rd_data_o     = data_q;
    assign outstanding_o = cnt_q;
endmodule

// File: rtl/ddr2_app_arbiter.sv
// ddr2_app_arbiter: round-robin write/read burst arbiter and sequencer for the MIG DDR2 user interface
module ddr2_app_arbiter
    import ddr2_app_pkg::*;
#(
    parameter int ADDR_WIDTH         = 31,
    parameter int APPDATA_WIDTH      = 32,
    parameter int BURST_BEATS        = 2,
    parameter int MAX_RD_OUTSTANDING = 4
) (
    input  logic                       clk0,
    input  logic                       rst0,
    input  logic                       phy_init_done,
    input  logic                       wr_req,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [APPDATA_WIDTH-1:0]   wr_data,
    input  logic [APPDATA_WIDTH/8-1:0] wr_mask,
    output logic                       wr_pop,
    output logic                       wr_ack,
    input  logic                       rd_req,
    input  logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_ack,
    output logic [APPDATA_WIDTH-1:0]   rd_data,
    output logic                       rd_valid,
    input  logic                       app_af_afull,
    input  logic                       app_wdf_afull,
    output logic                       app_af_wren,
    output logic [2:0]                 app_af_cmd,
    output logic [ADDR_WIDTH-1:0]      app_af_addr,
    output logic                       app_wdf_wren,
    output logic [APPDATA_WIDTH-1:0]   app_wdf_data,
    output logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
    input  logic                       rd_data_valid,
    input  logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
    output logic                       busy
);
    state_e     state_q, state_d;
    logic       last_rd_q, last_rd_d;
    logic [3:0] outstanding;
    logic       wr_ok, rd_ok, pick_wr, issue_d, wdf_d;

    assign wr_ok   = wr_req & ~app_af_afull & ~app_wdf_afull;
    assign rd_ok   = rd_req & ~app_af_afull & (outstanding < 4'(MAX_RD_OUTSTANDING));
    assign pick_wr = wr_ok & (~rd_ok | last_rd_q);

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        case (state_q)
            WAIT_INIT: state_d = phy_init_done ? IDLE : WAIT_INIT;
            IDLE: begin
                state_d   = pick_wr ? WR_B0 : rd_ok ? RD_CMD : IDLE;
                last_rd_d = pick_wr ? 1'b0 : rd_ok ? 1'b1 : last_rd_q;
            end
            WR_B0:   state_d = WR_B1;
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with the state they describe
    assign issue_d = state_d == WR_B0 || state_d == RD_CMD;
    assign wdf_d   = state_d == WR_B0 || state_d == WR_B1;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q           <= WAIT_INIT;
            last_rd_q         <= 1'b1;
            wr_pop            <= 1'b0;
            wr_ack            <= 1'b0;
            rd_ack            <= 1'b0;
            app_af_wren       <= 1'b0;
            app_af_cmd        <= CMD_WRITE;
            app_af_addr       <= '0;
            app_wdf_wren      <= 1'b0;
            app_wdf_data      <= '0;
            app_wdf_mask_data <= '0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_rd_q         <= last_rd_d;
            wr_pop            <= wdf_d;
            wr_ack            <= state_d == WR_B1;
            rd_ack            <= state_d == RD_CMD;
            app_af_wren       <= issue_d;
            app_af_cmd        <= state_d == RD_CMD ? CMD_READ : CMD_WRITE;
            app_af_addr       <= issue_d ? ADDR_WIDTH'(burst_addr_mask(64'(state_d == RD_CMD ? rd_addr : wr_addr))) : '0;
            app_wdf_wren      <= wdf_d;
            app_wdf_data      <= wdf_d ? wr_data : '0;
            app_wdf_mask_data <= wdf_d ? wr_mask : '0;
            busy              <= issue_d | wdf_d;
        end
    end

    ddr2_rd_tracker #(
        .APPDATA_WIDTH(APPDATA_WIDTH),
        .BURST_BEATS  (BURST_BEATS)
    ) u_trk (
        .clk_i             (clk0),
        .rst_i             (rst0),
        .issue_i           (state_q == RD_CMD),
        .rd_data_valid_i   (rd_data_valid),
        .rd_data_fifo_out_i(rd_data_fifo_out),
        .rd_valid_o        (rd_valid),
        .rd_data_o         (rd_data),
        .outstanding_o     (outstanding)
    );
endmodule

// File: tb/tb_ddr2_app_arbiter.sv
// tb_ddr2_app_arbiter: directed scoreboard bench for the DDR2 app arbiter
module tb_ddr2_app_arbiter;
    import ddr2_app_pkg::*;

    localparam int AW = 31;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk0 = 1'b0;
    logic          rst0, phy_init_done, wr_req, rd_req, app_af_afull, app_wdf_afull, rd_data_valid;
    logic [AW-1:0] wr_addr, rd_addr, app_af_addr;
    logic [DW-1:0] wr_data, rd_data_fifo_out, rd_data, app_wdf_data;
    logic [MW-1:0] wr_mask, app_wdf_mask_data;
    logic          wr_pop, wr_ack, rd_ack, rd_valid, app_af_wren, app_wdf_wren, busy;
    logic [2:0]    app_af_cmd;

    always #5 clk0 = ~clk0;

    ddr2_app_arbiter dut (
        .clk0(clk0), .rst0(rst0), .phy_init_done(phy_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_pop(wr_pop), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
        .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask_data(app_wdf_mask_data),
        .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int n_cmd = 0, n_pop = 0, n_wack = 0, n_rack = 0;
    int c0, r0, w0;
    logic [AW+2:0]    cmd_q[$];
    logic [DW+MW-1:0] wdf_q[$];
    logic [DW+MW-1:0] src_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {wr_pop, wr_ack, rd_ack, rd_valid, app_af_wren, app_af_cmd, app_wdf_wren, busy}, '0);
        chk({tag, "_bus"}, {app_af_addr, app_wdf_data, app_wdf_mask_data, rd_data}, '0);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [MW-1:0] m);
        cmd_q.push_back({CMD_WRITE, a[AW-1:2], 2'b00});
        src_q.push_back({m, d0});
        src_q.push_back({m, d1});
        wdf_q.push_back({m, d0});
        wdf_q.push_back({m, d1});
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        cmd_q.push_back({CMD_READ, a[AW-1:2], 2'b00});
    endtask

    task automatic ret_beat(input logic [DW-1:0] d);
        rd_data_valid    = 1'b1;
        rd_data_fifo_out = d;
        @(negedge clk0);
        chk("rd_return", {rd_valid, rd_data}, {1'b1, d});
    endtask

    task automatic do_reset();
        rst0 = 1'b1;
        repeat (2) @(negedge clk0);
        rst0 = 1'b0;
    endtask

    // write-data source reacts to wr_pop by presenting its next beat; command/data scoreboards
    always @(negedge clk0) begin
        logic [AW+2:0]    ec;
        logic [DW+MW-1:0] ed;
        if (app_af_wren) begin
            n_cmd++;
            ec = cmd_q.size() != 0 ? cmd_q.pop_front() : '1;
            chk("af_cmd_addr", {app_af_cmd, app_af_addr}, ec);
        end
        if (app_wdf_wren) begin
            ed = wdf_q.size() != 0 ? wdf_q.pop_front() : '1;
            chk("wdf_beat", {app_wdf_mask_data, app_wdf_data}, ed);
        end
        if (wr_pop) begin
            n_pop++;
            if (src_q.size() != 0) void'(src_q.pop_front());
        end
        if (wr_ack) n_wack++;
        if (rd_ack) n_rack++;
        wr_data = src_q.size() != 0 ? src_q[0][DW-1:0] : '0;
        wr_mask = src_q.size() != 0 ? src_q[0][DW+MW-1:DW] : '0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; phy_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        app_af_afull = 1'b0; app_wdf_afull = 1'b0; rd_data_valid = 1'b0;
        rd_data_fifo_out = '0; wr_addr = '0; rd_addr = '0;
        repeat (3) @(negedge clk0);
        check_zero("reset");
        chk("reset_state", dut.state_q, WAIT_INIT);
        rst0 = 1'b0;

        // init gating, then a single write
        push_wr(31'h105, 32'hA5A5_0001, 32'hA5A5_0002, 4'h0);
        wr_addr = 31'h105;
        wr_req  = 1'b1;
        repeat (50) @(negedge clk0);
        chk("init_gate_cmds", n_cmd, 0);
        chk("init_gate_busy", busy, 0);
        phy_init_done = 1'b1;
        @(negedge clk0);
        chk("init_lat1", app_af_wren, 0);
        @(negedge clk0);
        chk("wr_b0", {app_af_wren, app_wdf_wren, wr_pop, wr_ack, busy}, 5'b11101);
        @(negedge clk0);
        chk("wr_b1", {app_af_wren, app_wdf_wren, wr_pop, wr_ack}, 4'b0111);
        wr_req = 1'b0;
        @(negedge clk0);
        chk("wr_done", {wr_pop, wr_ack, busy}, 0);
        chk("wr_counts", {n_pop, n_wack}, {32'd2, 32'd1});

        // contention after reset: W first, then alternating
        push_wr(31'h2003, 32'h1000_0001, 32'h1000_0002, 4'h1);
        push_rd(31'h7FFF_FFFF);
        push_wr(31'h2003, 32'h2000_0001, 32'h2000_0002, 4'h2);
        push_rd(31'h7FFF_FFFF);
        push_wr(31'h2003, 32'h3000_0001, 32'h3000_0002, 4'h4);
        do_reset();
        @(negedge clk0);
        c0 = n_cmd; w0 = n_wack; r0 = n_rack;
        wr_addr = 31'h2003; rd_addr = 31'h7FFF_FFFF;
        wr_req = 1'b1; rd_req = 1'b1;
        repeat (12) @(negedge clk0);
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clk0);
        chk("cont_cmds", n_cmd - c0, 5);
        chk("cont_acks", {n_wack - w0, n_rack - r0}, {32'd3, 32'd2});
        chk("cont_outstanding", dut.outstanding, 2);

        // drain both reads
        ret_beat(32'h1111_0001);
        ret_beat(32'h1111_0002);
        ret_beat(32'h2222_0001);
        ret_beat(32'h2222_0002);
        rd_data_valid = 1'b0;
        chk("drain_outstanding", dut.outstanding, 0);
        @(negedge clk0);
        chk("rd_valid_clear", rd_valid, 0);
        chk("no_underflow", dut.u_trk.err_underflow_q, 0);

        // stray beat with nothing outstanding
        ret_beat(32'hDEAD_BEEF);
        rd_data_valid = 1'b0;
        chk("underflow_flag", dut.u_trk.err_underflow_q, 1);
        chk("underflow_count", dut.outstanding, 0);

        // outstanding limit
        repeat (4) push_rd(31'h41);
        do_reset();
        @(negedge clk0);
        r0 = n_rack;
        rd_addr = 31'h41;
        rd_req  = 1'b1;
        repeat (20) @(negedge clk0);
        chk("limit_reads", n_rack - r0, 4);
        chk("limit_outstanding", dut.outstanding, 4);
        push_rd(31'h41);
        ret_beat(32'h4444_0001);
        ret_beat(32'h4444_0002);
        rd_data_valid = 1'b0;
        repeat (4) @(negedge clk0);
        chk("limit_fifth", n_rack - r0, 5);
        rd_req = 1'b0;
        chk("limit_outstanding2", dut.outstanding, 4);

        // write-data backpressure: only reads until afull drops
        repeat (3) push_rd(31'h41);
        push_wr(31'h300, 32'h5555_0001, 32'h5555_0002, 4'h8);
        do_reset();
        @(negedge clk0);
        r0 = n_rack; w0 = n_wack;
        wr_addr = 31'h300;
        app_wdf_afull = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        repeat (6) @(negedge clk0);
        chk("bp_reads", n_rack - r0, 3);
        chk("bp_writes", n_wack - w0, 0);
        app_wdf_afull = 1'b0;
        @(negedge clk0);
        chk("bp_wr_grant", {app_af_wren, app_af_cmd}, {1'b1, CMD_WRITE});
        @(negedge clk0);
        chk("bp_wr_ack", wr_ack, 1);
        wr_req = 1'b0; rd_req = 1'b0;

        // reset in the middle of a write burst
        push_wr(31'h7_0009, 32'h6666_0001, 32'h6666_0002, 4'h3);
        @(negedge clk0);
        wr_addr = 31'h7_0009;
        wr_req  = 1'b1;
        @(negedge clk0);
        chk("mb_b0", app_af_wren, 1);
        @(negedge clk0);
        chk("mb_b1", wr_ack, 1);
        rst0 = 1'b1; wr_req = 1'b0;
        @(negedge clk0);
        check_zero("mb_reset");
        chk("mb_state", dut.state_q, WAIT_INIT);
        rst0 = 1'b0;
        @(negedge clk0);
        chk("mb_idle", dut.state_q, IDLE);

        repeat (2) @(negedge clk0);
        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("wdf_q_empty", wdf_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
